// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational 32-bit ALU between NUM_REQ
// requesters. Round-robin grant, valid/ready request handshake, registered
// operands to the ALU and a held, registered response per requester.
// Optional build macro ALU_ARB_ILLEGAL_CHK_EN: flags func 3'b011 as illegal,
// forcing a zero result/carry and raising o_rsp_err for that response.
module alu_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int GW      = 2
) (
   input  logic                 i_clk,
   input  logic                 i_rstn,
   input  logic [NUM_REQ-1:0]   i_req_valid,
   output logic [NUM_REQ-1:0]   o_req_ready,
   input  logic [NUM_REQ*32-1:0] i_req_a,
   input  logic [NUM_REQ*32-1:0] i_req_b,
   input  logic [NUM_REQ*3-1:0] i_req_func,
   output logic [NUM_REQ-1:0]   o_rsp_valid,
   input  logic [NUM_REQ-1:0]   i_rsp_ready,
   output logic [31:0]          o_rsp_y,
   output logic                 o_rsp_c,
   output logic                 o_rsp_err,
   output logic [31:0]          o_alu_a,
   output logic [31:0]          o_alu_b,
   output logic [2:0]           o_alu_func,
   input  logic [31:0]          i_alu_y,
   input  logic                 i_alu_c,
   output logic                 o_busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              r_state;
   logic [GW-1:0]       r_ptr;
   logic [GW-1:0]       r_gnt;
   logic [31:0]         r_a;
   logic [31:0]         r_b;
   logic [2:0]          r_func;
   logic [31:0]         r_y;
   logic                r_c;
   logic [NUM_REQ-1:0]  r_rsp_valid;

   logic                w_found;
   logic [GW-1:0]       w_gnt;
   int                  w_idx;
   logic [31:0]         w_a;
   logic [31:0]         w_b;
   logic [2:0]          w_func;
   logic                w_rsp_acc;

`ifdef ALU_ARB_ILLEGAL_CHK_EN
   logic                r_err;
`endif

   // Round-robin search: first valid requester at or after the pointer, wrapping.
   always_comb begin
      w_found = 1'b0;
      w_gnt   = '0;
      w_idx   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx = (int'(r_ptr) + k) % NUM_REQ;
         if (!w_found && i_req_valid[w_idx]) begin
            w_found = 1'b1;
            w_gnt   = GW'(w_idx);
         end
      end
   end

   // Accept strobe and operand mux for the granted requester.
   always_comb begin
      o_req_ready = '0;
      w_a         = '0;
      w_b         = '0;
      w_func      = '0;
      for (int n = 0; n < NUM_REQ; n++) begin
         if (w_gnt == GW'(n)) begin
            o_req_ready[n] = (r_state == IDLE) && w_found;
            w_a            = i_req_a[32*n +: 32];
            w_b            = i_req_b[32*n +: 32];
            w_func         = i_req_func[3*n +: 3];
         end
      end
   end

   // Only the granted requester's response-ready bit can complete a response.
   assign w_rsp_acc = |(i_rsp_ready & r_rsp_valid);

   // Transaction FSM: IDLE accepts, EXEC samples the ALU, RESP holds until taken.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_state     <= IDLE;
         r_ptr       <= '0;
         r_gnt       <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_func      <= '0;
         r_y         <= '0;
         r_c         <= 1'b0;
         r_rsp_valid <= '0;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
         r_err       <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_gnt   <= w_gnt;
                  r_a     <= w_a;
                  r_b     <= w_b;
                  r_func  <= w_func;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
                  r_err   <= (w_func == 3'b011);
`endif
                  r_state <= EXEC;
               end
            end
            EXEC: begin
`ifdef ALU_ARB_ILLEGAL_CHK_EN
               r_y <= r_err ? 32'd0 : i_alu_y;
               r_c <= r_err ? 1'b0  : i_alu_c;
`else
               r_y <= i_alu_y;
               r_c <= i_alu_c;
`endif
               for (int n = 0; n < NUM_REQ; n++) begin
                  r_rsp_valid[n] <= (r_gnt == GW'(n));
               end
               r_state <= RESP;
            end
            RESP: begin
               if (w_rsp_acc) begin
                  r_rsp_valid <= '0;
                  r_ptr       <= (r_gnt == GW'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Operand registers only change at accept, so they hold outside EXEC.
   assign o_alu_a     = r_a;
   assign o_alu_b     = r_b;
   assign o_alu_func  = r_func;
   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_y     = r_y;
   assign o_rsp_c     = r_c;
   assign o_busy      = (r_state != IDLE);
`ifdef ALU_ARB_ILLEGAL_CHK_EN
   assign o_rsp_err   = r_err;
`else
   assign o_rsp_err   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: drives alu_arbiter with directed and random traffic, supplies
// the external ALU, and compares every cycle against a transaction-timeline model.
module tb_alu_arbiter;
   localparam int NUM_REQ = 2;
   localparam int GW      = 2;
`ifdef ALU_ARB_ILLEGAL_CHK_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   logic                  clk = 1'b0;
   logic                  rstn;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ*32-1:0] req_a;
   logic [NUM_REQ*32-1:0] req_b;
   logic [NUM_REQ*3-1:0]  req_func;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic [NUM_REQ-1:0]    rsp_ready;
   logic [31:0]           rsp_y;
   logic                  rsp_c;
   logic                  rsp_err;
   logic [31:0]           alu_a;
   logic [31:0]           alu_b;
   logic [2:0]            alu_func;
   logic [31:0]           alu_y;
   logic                  alu_c;
   logic                  busy;

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   alu_arbiter #(.NUM_REQ(NUM_REQ), .GW(GW)) dut (
      .i_clk(clk), .i_rstn(rstn),
      .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req_a(req_a), .i_req_b(req_b), .i_req_func(req_func),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
      .o_rsp_y(rsp_y), .o_rsp_c(rsp_c), .o_rsp_err(rsp_err),
      .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_func(alu_func),
      .i_alu_y(alu_y), .i_alu_c(alu_c), .o_busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference ALU: AND/OR/ADD/SLT on A and (optionally inverted) B, no carry-in.
   function automatic logic [32:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] f);
      logic [31:0] bb;
      logic [32:0] s;
      logic [31:0] y;
      bb = f[2] ? ~b : b;
      s  = {1'b0, a} + {1'b0, bb};
      case (f[1:0])
         2'b00:   y = a & bb;
         2'b01:   y = a | bb;
         2'b10:   y = s[31:0];
         default: y = f[2] ? {31'd0, s[31]} : 32'd0;
      endcase
      return {s[32], y};
   endfunction

   always_comb {alu_c, alu_y} = alu_ref(alu_a, alu_b, alu_func);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural model ----------------
   // m_age: -1 when no transaction is outstanding, else cycles since accept.
   bit          m_known = 1'b0;
   int          m_age, m_ptr, m_gnt;
   logic [31:0] m_a, m_b, m_y;
   logic [2:0]  m_f;
   logic        m_c, m_err;

   function automatic int pick(input int ptr, input logic [NUM_REQ-1:0] v);
      for (int k = 0; k < NUM_REQ; k++)
         if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
      return -1;
   endfunction

   always @(negedge clk) begin
      logic [NUM_REQ-1:0] e_ready, e_rsp;
      logic [32:0]        r;
      int                 g;
      if (m_known) begin
         e_ready = '0;
         e_rsp   = '0;
         g = pick(m_ptr, req_valid);
         if (m_age < 0 && g >= 0) e_ready[g] = 1'b1;
         if (m_age >= 2) e_rsp[m_gnt] = 1'b1;
         chk("req_ready", req_ready, e_ready);
         chk("rsp_valid", rsp_valid, e_rsp);
         chk("rsp_y", rsp_y, m_y);
         chk("rsp_c", rsp_c, m_c);
         chk("rsp_err", rsp_err, m_err);
         chk("alu_ops", {alu_f_pad(alu_func), alu_a, alu_b}, {alu_f_pad(m_f), m_a, m_b});
         chk("busy", busy, m_age >= 1);
      end
      if (!rstn) begin
         m_known = 1'b1;
         m_age = -1; m_ptr = 0; m_gnt = 0;
         m_a = 0; m_b = 0; m_f = 0; m_y = 0; m_c = 0; m_err = 0;
      end else if (m_known) begin
         g = pick(m_ptr, req_valid);
         if (m_age < 0) begin
            if (g >= 0) begin
               m_gnt = g;
               m_a   = req_a[32*g +: 32];
               m_b   = req_b[32*g +: 32];
               m_f   = req_func[3*g +: 3];
               m_err = CHK_EN && (m_f == 3'b011);
               m_age = 1;
            end
         end else if (m_age == 1) begin
            r = alu_ref(m_a, m_b, m_f);
            m_y = m_err ? 32'd0 : r[31:0];
            m_c = m_err ? 1'b0 : r[32];
            m_age = 2;
         end else if (rsp_ready[m_gnt]) begin
            m_age = -1;
            m_ptr = (m_gnt + 1) % NUM_REQ;
         end else begin
            m_age++;
         end
      end
   end

   function automatic logic [31:0] alu_f_pad(input logic [2:0] f);
      return {29'd0, f};
   endfunction

   // ---------------- directed helpers ----------------
   task automatic txn(input int n, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] f, output logic [31:0] y, output logic c,
                      output logic e, output int lat);
      int t0;
      bit ok;
      @(posedge clk); #1;
      req_a[32*n +: 32] = a;
      req_b[32*n +: 32] = b;
      req_func[3*n +: 3] = f;
      req_valid[n] = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (req_ready[n]) ok = 1'b1;
      end
      if (!ok) chk("timeout_accept", 0, 1);
      t0 = cyc;
      @(posedge clk); #1;
      req_valid[n] = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         if (rsp_valid[n]) ok = 1'b1;
      end
      if (!ok) chk("timeout_rsp", 0, 1);
      lat = cyc - t0;
      y = rsp_y; c = rsp_c; e = rsp_err;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 30 && !ok; i++) begin
         @(negedge clk);
         if (!busy) ok = 1'b1;
      end
      if (!ok) chk("timeout_idle", 0, 1);
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_rsp_valid"}, rsp_valid, 0);
      chk({tag, "_y"}, rsp_y, 0);
      chk({tag, "_c"}, rsp_c, 0);
      chk({tag, "_alu_a"}, alu_a, 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] y, y0;
      logic c, e;
      int lat, g, prev, cnt;
      rstn = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_func = '0; rsp_ready = '1;
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      @(negedge clk);
      check_zero("reset");

      // Add and inverted-B operations with hand-computed results.
      txn(0, 32'd5, 32'd3, 3'b010, y, c, e, lat);
      chk("add_y", y, 32'h8); chk("add_c", c, 0); chk("add_lat", lat, 2);
      txn(1, 32'd5, 32'd3, 3'b110, y, c, e, lat);
      chk("inv_y", y, 32'h1); chk("inv_c", c, 1);
      txn(1, 32'd3, 32'd5, 3'b111, y, c, e, lat);
      chk("slt_lt_y", y, 32'h1);
      txn(1, 32'd5, 32'd3, 3'b111, y, c, e, lat);
      chk("slt_ge_y", y, 32'h0);
      wait_idle();

      // Round robin with both requesters continuously valid.
      @(posedge clk); #1;
      req_a = {32'd20, 32'd10}; req_b = {32'd2, 32'd1}; req_func = {3'b010, 3'b010};
      req_valid = '1;
      cnt = 0; prev = 0;
      for (int i = 0; i < 40 && cnt < 4; i++) begin
         @(negedge clk);
         if (req_ready != 0) begin
            g = (req_ready == 2'b10) ? 1 : 0;
            chk("rr_grant", g, cnt % 2);
            if (cnt > 0) chk("rr_spacing", cyc - prev, 3);
            prev = cyc;
            cnt++;
         end
      end
      if (cnt < 4) chk("timeout_rr", cnt, 4);
      @(posedge clk); #1 req_valid = '0;
      wait_idle();

      // Backpressure: non-granted ready bit high, granted bit low for 5 cycles.
      rsp_ready = 2'b10;
      txn(0, 32'h1234_0000, 32'h0000_5678, 3'b010, y0, c, e, lat);
      chk("bp_y0", y0, 32'h1234_5678);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1 req_valid[1] = ~req_valid[1];
         @(negedge clk);
         chk("bp_valid", rsp_valid, 2'b01);
         chk("bp_y", rsp_y, y0);
         chk("bp_ready", req_ready, 0);
      end
      @(posedge clk); #1 rsp_ready = '1; req_valid = '0;
      @(negedge clk);
      chk("bp_rel_valid", rsp_valid, 2'b01);
      @(negedge clk);
      chk("bp_done_valid", rsp_valid, 0);
      wait_idle();

      // Reset during EXEC.
      txn(0, 32'd7, 32'd9, 3'b010, y, c, e, lat);
      chk("pre_rst_y", y, 32'd16);
      @(posedge clk); #1 req_valid[1] = 1'b1;
      @(negedge clk);
      chk("rst_exec_grant", req_ready, 2'b10);
      @(posedge clk); #1 req_valid = '0; rstn = 1'b0;
      @(negedge clk);
      chk("rst_exec_busy", busy, 1);
      @(posedge clk); #1 rstn = 1'b1;
      @(negedge clk);
      check_zero("rst_exec");
      @(posedge clk); #1 req_valid = '1;
      @(negedge clk);
      chk("rst_exec_first", req_ready, 2'b01);
      @(posedge clk); #1 req_valid = '0;
      wait_idle();

      // Reset during RESP.
      rsp_ready = '0;
      @(posedge clk); #1 req_valid[1] = 1'b1;
      @(negedge clk);
      chk("rst_resp_grant", req_ready, 2'b10);
      @(posedge clk); #1 req_valid = '0;
      @(posedge clk); #1 rstn = 1'b0;
      @(negedge clk);
      chk("rst_resp_valid", rsp_valid, 2'b10);
      @(posedge clk); #1 rstn = 1'b1;
      @(negedge clk);
      check_zero("rst_resp");
      rsp_ready = '1;
      @(posedge clk); #1 req_valid = '1;
      @(negedge clk);
      chk("rst_resp_first", req_ready, 2'b01);
      @(posedge clk); #1 req_valid = '0;
      wait_idle();

      // func 011 handling.
      txn(0, 32'hFFFF_FFFF, 32'd1, 3'b011, y, c, e, lat);
      chk("ill_y", y, 32'd0);
      chk("ill_err", e, CHK_EN ? 1 : 0);
      chk("ill_c", c, CHK_EN ? 0 : 1);
      wait_idle();

      // Random traffic with occasional reset.
      for (int i = 0; i < 600; i++) begin
         @(posedge clk); #1;
         req_valid = NUM_REQ'($urandom);
         rsp_ready = NUM_REQ'($urandom);
         for (int n = 0; n < NUM_REQ; n++) begin
            req_a[32*n +: 32]  = $urandom;
            req_b[32*n +: 32]  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            req_func[3*n +: 3] = 3'($urandom);
         end
         rstn = ($urandom_range(0, 59) != 0);
      end
      @(posedge clk); #1 rstn = 1'b1; req_valid = '0; rsp_ready = '1;
      repeat (6) @(posedge clk);
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one combinational 32-bit ALU instance (A, B, 3-bit func in; Y, carry out) between NUM_REQ requesters.
- Round-robin arbitration, valid/ready request handshake, registered operands to the ALU, and a registered, held response per requester.
- Sits between the core's issue agents and the single ALU, which is instantiated outside this block and wired through the o_alu_* / i_alu_* ports.

Parameters:
- NUM_REQ, 2: number of requesters. Legal range 2..4.
- GW, 2: width of the grant index. Must satisfy 2**GW >= NUM_REQ.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rstn  in  1  synchronous active-low reset.
- i_req_valid  in  NUM_REQ  per-requester request valid.
- o_req_ready  out  NUM_REQ  per-requester accept strobe (one-hot or zero).
- i_req_a  in  NUM_REQ*32  operand A, requester n at bits [32n+31:32n].
- i_req_b  in  NUM_REQ*32  operand B, same packing as i_req_a.
- i_req_func  in  NUM_REQ*3  ALU function, requester n at bits [3n+2:3n].
- o_rsp_valid  out  NUM_REQ  response valid for requester n (one-hot or zero).
- i_rsp_ready  in  NUM_REQ  per-requester response accept.
- o_rsp_y  out  32  registered result.
- o_rsp_c  out  1  registered carry.
- o_rsp_err  out  1  illegal-function flag (see Optional Feature).
- o_alu_a  out  32  operand A to the ALU.
- o_alu_b  out  32  operand B to the ALU.
- o_alu_func  out  3  function select to the ALU.
- i_alu_y  in  32  ALU result.
- i_alu_c  in  1  ALU carry out.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (i_rstn low at a clock edge): all outputs 0, state IDLE, round-robin pointer 0, operand/func/result registers 0. Applies in any state; an in-flight transaction is dropped with no response.
- FSM has three states: IDLE, EXEC, RESP.
- IDLE:
  - If any i_req_valid is set, grant the first valid index at or after the pointer, searching cyclically from the pointer upward and wrapping.
  - o_req_ready[grant] is asserted combinationally in that cycle only, so the handshake completes in that cycle.
  - Latch the granted requester's a, b, func and grant index; go to EXEC.
  - If nothing is valid, stay in IDLE with o_req_ready = 0.
- EXEC (exactly one cycle):
  - o_alu_a, o_alu_b and o_alu_func drive the latched registers. In every other state they hold their last value.
  - At the clock edge, capture i_alu_y into o_rsp_y and i_alu_c into o_rsp_c; go to RESP.
- RESP:
  - o_rsp_valid[grant] = 1. o_rsp_y, o_rsp_c and o_rsp_err stay stable until acceptance.
  - When i_rsp_ready[grant] = 1, clear o_rsp_valid, set pointer = (grant+1) mod NUM_REQ and go to IDLE.
  - i_rsp_ready bits for non-granted indices are ignored.
- Latency: accept at edge T, EXEC during cycle T+1, o_rsp_valid high from cycle T+2. Minimum 3 cycles per transaction, so peak throughput is 1 op per 3 cycles.
- No new request is accepted in EXEC or RESP; o_req_ready is 0 there.
- Requester inputs only need to be stable in the accept cycle.
- A requester whose valid drops before grant is simply not granted; no state is kept for it.
- Arithmetic is the ALU's, unchanged:
  - func[2] selects inverted B.
  - No +1 carry-in, so func 110 yields A + ~B (not A − B), with carry.
  - The arbiter never modifies operands or results.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NUM_REQ−1,0,…. No requester waits more than NUM_REQ−1 transactions.

Optional Feature:
- Macro: ALU_ARB_ILLEGAL_CHK_EN.
- Defined:
  - func 3'b011 is flagged at accept: o_rsp_err = 1 in RESP.
  - o_rsp_y = 0 and o_rsp_c = 0 are forced for that response.
  - The EXEC cycle still occurs, so timing is identical.
  - For all other funcs, o_rsp_err = 0.
- Undefined:
  - o_rsp_err is tied to 0.
  - func 011 is passed through, and the ALU's own output (default 0 result plus its carry) is returned as-is.

Test Plan:
- Add, requester 0: a=5, b=3, func=010 → o_req_ready[0] in the accept cycle; o_rsp_valid[0] 2 cycles later with y=0x00000008, c=0.
- Inverted add, requester 1: a=5, b=3, func=110 → y=0x00000001, c=1. Then func=111 with a=3, b=5 → y=1; with a=5, b=3 → y=0.
- Round robin: both requesters hold valid with i_rsp_ready=1 continuously → grant order 0,1,0,1. Each accept is spaced 3 cycles apart; o_rsp_valid is never asserted on the wrong index.
- Backpressure: in RESP, hold i_rsp_ready[grant]=0 for 5 cycles with i_req_valid toggling → o_rsp_valid and y stay stable, o_req_ready=0 throughout; accept proceeds one cycle after release.
- Reset in EXEC and in RESP: drive i_rstn=0 for one edge → next cycle all outputs 0, state IDLE, pointer 0; the following request is granted to index 0 first.
- With ALU_ARB_ILLEGAL_CHK_EN defined, func=011, a=0xFFFFFFFF, b=1 → o_rsp_err=1, y=0, c=0. Without the macro → o_rsp_err=0 and y=0.
